fetch_stage: RTL

//  IF stage plus IF/ID pipeline register of the pipelined MIPS core.
//  - Owns the PC and drives the instruction-memory address.
//  - Latches the fetched word into the decode stage; opD/functD feed the main/ALU decoder directly.
//  - Applies branch/jump redirects resolved in decode, and squashes the wrong-path fetch.
//  - Honours stall/flush from the hazard unit and counts instructions delivered to decode.

---
 rtl/mips_pkg.sv | 23 ++
 rtl/flopenrc.sv | 21 ++
 rtl/fetch_stage.sv | 105 ++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared constants, instruction field positions and pipeline payload types
// for the pipelined MIPS core.
package mips_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  localparam int unsigned OP_MSB    = 31;
  localparam int unsigned OP_LSB    = 26;
  localparam int unsigned FUNCT_MSB = 5;
  localparam int unsigned FUNCT_LSB = 0;
  localparam int unsigned JIMM_MSB  = 25;
  localparam int unsigned JIMM_LSB  = 0;

  typedef struct packed {
    logic [31:0]      instr;
    logic [XLEN-1:0]  pcplus4;
    logic             valid;
  } ifid_t;

endpackage

// File: rtl/flopenrc.sv
// Register with load enable and synchronous clear; clear beats enable.
module flopenrc #(
  parameter int unsigned       WIDTH   = 8,
  parameter logic [WIDTH-1:0]  CLR_VAL = '0
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (clr) begin
      q <= CLR_VAL;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// IF stage and IF/ID pipeline register: PC, next-PC selection, redirect
// squash, stall handling and a count of instructions delivered to decode.
module fetch_stage
  import mips_pkg::*;
#(
  parameter int unsigned       WIDTH     = XLEN,
  parameter logic [WIDTH-1:0]  RESET_PC  = mips_pkg::RESET_PC,
  parameter logic [31:0]       NOP_INSTR = mips_pkg::NOP_INSTR
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stallF,
  input  logic             stallD,
  input  logic             flushD,
  input  logic             pcsrcD,
  input  logic [WIDTH-1:0] pcbranchD,
  input  logic             jumpD,
  output logic [WIDTH-1:0] imem_addr,
  input  logic [31:0]      imem_rdata,
  output logic [31:0]      instrD,
  output logic [WIDTH-1:0] pcplus4D,
  output logic             validD,
  output logic [5:0]       opD,
  output logic [5:0]       functD,
  output logic [31:0]      fetch_count
);

  localparam int unsigned  IFID_W   = $bits(ifid_t);
  localparam logic [IFID_W-1:0] IFID_CLR = {NOP_INSTR, WIDTH'(0), 1'b0};

  logic [WIDTH-1:0] pcF;
  logic [WIDTH-1:0] pcplus4F;
  logic [WIDTH-1:0] pcnextF;
  logic [WIDTH-1:0] jtarget;
  logic [WIDTH-1:0] btarget;
  logic             redirect;
  logic             squash;
  logic             load_valid;
  ifid_t            ifid_d;
  ifid_t            ifid_q;

  assign pcplus4F = pcF + WIDTH'(4);
  assign jtarget  = {ifid_q.pcplus4[WIDTH-1:28], ifid_q.instr[JIMM_MSB:JIMM_LSB], 2'b00};
  assign btarget  = {pcbranchD[WIDTH-1:2], 2'b00};

  // A redirect is only honoured once decode is no longer stalled.
  assign redirect   = (jumpD | pcsrcD) & ~stallD;
  assign squash     = flushD | redirect;
  assign load_valid = ~stallD & ~squash;

  always_comb begin
    pcnextF = pcplus4F;
    if (redirect) begin
      pcnextF = jumpD ? jtarget : btarget;
    end
  end

  flopenrc #(
    .WIDTH   (WIDTH),
    .CLR_VAL (RESET_PC)
  ) u_pc_reg (
    .clk (clk),
    .clr (reset),
    .en  (~stallF),
    .d   (pcnextF),
    .q   (pcF)
  );

  always_comb begin
    ifid_d.instr   = imem_rdata;
    ifid_d.pcplus4 = pcplus4F;
    ifid_d.valid   = 1'b1;
    if (squash) begin
      ifid_d.instr = NOP_INSTR;
      ifid_d.valid = 1'b0;
    end
  end

  flopenrc #(
    .WIDTH   (IFID_W),
    .CLR_VAL (IFID_CLR)
  ) u_ifid_reg (
    .clk (clk),
    .clr (reset),
    .en  (~stallD),
    .d   (ifid_d),
    .q   (ifid_q)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_count <= 32'd0;
    end else if (load_valid) begin
      fetch_count <= fetch_count + 32'd1;
    end
  end

  assign imem_addr = pcF;
  assign instrD    = ifid_q.instr;
  assign pcplus4D  = ifid_q.pcplus4;
  assign validD    = ifid_q.valid;
  assign opD       = ifid_q.instr[OP_MSB:OP_LSB];
  assign functD    = ifid_q.instr[FUNCT_MSB:FUNCT_LSB];

endmodule
